data_mem_responder: RTL

Data-memory responder for the pipeline's memory stage. Accepts the stage's word-addressed read/write requests (read, write, 30-bit word address, 32-bit store data, 4-bit byte enable) and performs them on an internal word RAM. Returns the loaded word to the write-back stage's memory-data input after a programmable number of wait states. A ready/valid handshake lets the pipeline stall while an access is in flight.

---
 rtl/data_mem_if.sv | 23 ++
 rtl/data_mem_responder.sv | 105 ++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// The memory stage is the master; the responder is the slave.
interface data_mem_if;
  logic        read_in;
  logic        write_in;
  logic [29:0] addr_in;
  logic [31:0] wdata_in;
  logic [3:0]  byte_enable_in;
  logic [31:0] rdata_out;
  logic        rvalid_out;
  logic        ready_out;
  logic        error_out;

  modport master (
    output read_in, write_in, addr_in, wdata_in, byte_enable_in,
    input  rdata_out, rvalid_out, ready_out, error_out
  );

  modport slave (
    input  read_in, write_in, addr_in, wdata_in, byte_enable_in,
    output rdata_out, rvalid_out, ready_out, error_out
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM for the memory stage: one access in flight at a time,
// completing WAIT_STATES+1 cycles after acceptance with rvalid/error pulses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);

  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state;
  logic [3:0]            cnt;
  logic                  read_q;
  logic                  write_q;
  logic [29:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic [31:0]           mem [DEPTH_WORDS];

  logic                  in_range;
  logic                  finishing;
  logic                  commit_write;
  logic [ADDR_BITS-1:0]  idx;

  // Full 30-bit compare so high address bits can never alias into the RAM.
  assign in_range     = addr_q < DEPTH_LIMIT;
  assign idx          = addr_q[ADDR_BITS-1:0];
  assign finishing    = (state == BUSY) && (cnt == 4'd0);
  assign commit_write = finishing && write_q && !read_q && in_range;

  // NOTE: the RAM has no reset; putting it in the async-reset block would turn
  // every word into a resettable flop. A reset mid-access still blocks the
  // commit because state drops to IDLE asynchronously, clearing commit_write.
  always_ff @(posedge clk) begin
    if (commit_write) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (be_q[lane]) mem[idx][lane*8 +: 8] <= wdata_q[lane*8 +: 8];
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      bus.rdata_out <= '0;
      bus.rvalid_out <= 1'b0;
      bus.ready_out <= 1'b1;
      bus.error_out <= 1'b0;
    end else begin
      bus.rvalid_out <= 1'b0;
      bus.error_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.read_in || bus.write_in) begin
            read_q        <= bus.read_in;
            write_q       <= bus.write_in;
            addr_q        <= bus.addr_in;
            wdata_q       <= bus.wdata_in;
            be_q          <= bus.byte_enable_in;
            cnt           <= 4'(WAIT_STATES);
            bus.ready_out <= 1'b0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state         <= IDLE;
            bus.ready_out <= 1'b1;
            if (read_q && write_q) begin
              // Conflicting request: run the latency, report, touch nothing.
              bus.error_out <= 1'b1;
            end else if (read_q) begin
              bus.rvalid_out <= 1'b1;
              if (in_range) begin
                bus.rdata_out <= mem[idx];
              end else begin
                bus.rdata_out <= '0;
                bus.error_out <= 1'b1;
              end
            end else if (!in_range) begin
              bus.error_out <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
